// File: rtl/lsu_bus_master_pkg.sv
// rtl/lsu_bus_master_pkg.sv - shared types and decode helpers for the load/store bus master
//
// Holds the FSM state encoding, the RV32I load/store funct3 codes and the
// small decode functions used by the top level and the load formatter.

package lsu_bus_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ERR      = 3'd1,
        S_ST       = 3'd2,
        S_LD_ISSUE = 3'd3,
        S_LD_WAIT  = 3'd4,
        S_RESP     = 3'd5
    } lsu_state_t;

    // Loads use all five codes; stores only the first three.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size in bytes, from the low two funct3 bits.
    function automatic logic [2:0] access_bytes(input logic [1:0] f3_size);
        case (f3_size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// rtl/lsu_load_fmt.sv - combinational load data extraction and extension
//
// Ports:
//   word    in  32  raw memory word; byte at offset k sits in word[31-8k -: 8]
//   offset  in  2   byte offset of the access inside the word (already aligned)
//   funct3  in  3   load width/sign code
//   result  out 32  sign- or zero-extended load value (0 for unknown codes)

module lsu_load_fmt
    import lsu_bus_master_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    // The responder returns bytes in descending lane order, so offset 0 is the MSB.
    function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    logic [7:0] b_lo;
    logic [7:0] b_hi;

    always_comb begin
        b_lo = byte_at(word, offset);
        // Halfwords are only ever at offset 0 or 2, so the +1 never wraps in use.
        b_hi = byte_at(word, offset + 2'd1);
        case (funct3)
            F3_B:    result = {{24{b_lo[7]}}, b_lo};
            F3_BU:   result = {24'd0, b_lo};
            F3_H:    result = {{16{b_hi[7]}}, b_hi, b_lo};
            F3_HU:   result = {16'd0, b_hi, b_lo};
            F3_W:    result = {word[7:0], word[15:8], word[23:16], word[31:24]};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - RV32I load/store initiator for the word-addressed data memory
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake; ready only while idle
//   req_we, req_funct3        store/load select and width/sign code
//   req_addr, req_wdata       byte address and right-justified store data
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      extended load result, error flag
//   mem_strb, mem_addr        read strobe and word-aligned byte address
//   mem_wdata, mem_wmask      lane-formatted store data and byte enables
//   mem_rdata                 read word, valid the cycle after mem_strb

module lsu_bus_master
    import lsu_bus_master_pkg::*;
#(
    parameter int MEM_BYTES   = 2048,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_strb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_q, state_d;

    logic [2:0]  ld_funct3_q, ld_funct3_d;
    logic [1:0]  ld_off_q, ld_off_d;

    logic        resp_valid_d, resp_err_d, mem_strb_d;
    logic [31:0] resp_rdata_d, mem_addr_d, mem_wdata_d;
    logic [3:0]  mem_wmask_d;

    logic [2:0]  size;
    logic        legal, misaligned, out_of_range, req_err;
    logic [1:0]  eff_off;
    logic [32:0] last_addr;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] ld_result;

    assign req_ready = (state_q == S_IDLE);

    // Request decode, evaluated on the live request fields at the accept edge.
    always_comb begin
        size       = access_bytes(req_funct3[1:0]);
        legal      = funct3_legal(req_we, req_funct3);
        misaligned = 1'b0;
        if (CHECK_ALIGN) begin
            misaligned = ((size == 3'd2) && req_addr[0]) ||
                         ((size == 3'd4) && (req_addr[1:0] != 2'b00));
        end
        // With alignment checking off, low bits are dropped instead of flagged.
        case (size)
            3'd1:    eff_off = req_addr[1:0];
            3'd2:    eff_off = {req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
        // 33 bits so an access near 4 GiB cannot wrap back into range.
        last_addr    = {1'b0, req_addr[31:2], eff_off} + {30'd0, size} - 33'd1;
        out_of_range = (last_addr >= 33'(MEM_BYTES));
        req_err      = !legal || misaligned || out_of_range;
    end

    // Store lane formatting: byte i of the data goes to lane eff_off+i.
    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << eff_off;
                st_data = {24'd0, req_wdata[7:0]} << {eff_off, 3'b000};
            end
            2'b01: begin
                st_mask = 4'b0011 << eff_off;
                st_data = {16'd0, req_wdata[15:0]} << {eff_off, 3'b000};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    lsu_load_fmt u_load_fmt (
        .word   (mem_rdata),
        .offset (ld_off_q),
        .funct3 (ld_funct3_q),
        .result (ld_result)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d      = state_q;
        ld_funct3_d  = ld_funct3_q;
        ld_off_d     = ld_off_q;
        mem_addr_d   = mem_addr;
        mem_strb_d   = 1'b0;
        mem_wmask_d  = 4'b0000;
        mem_wdata_d  = 32'd0;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err;
        resp_rdata_d = resp_rdata;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    ld_funct3_d = req_funct3;
                    ld_off_d    = eff_off;
                    if (req_err) begin
                        state_d      = S_ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (req_we) begin
                        state_d     = S_ST;
                        mem_wmask_d = st_mask;
                        mem_wdata_d = st_data;
                    end else begin
                        state_d    = S_LD_ISSUE;
                        mem_strb_d = 1'b1;
                    end
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            S_ST: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'd0;
            end
            S_LD_ISSUE: begin
                state_d = S_LD_WAIT;
            end
            S_LD_WAIT: begin
                // mem_rdata is valid now; format it straight into the response.
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = ld_result;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            ld_funct3_q <= 3'd0;
            ld_off_q    <= 2'd0;
            mem_addr    <= 32'd0;
            mem_strb    <= 1'b0;
            mem_wmask   <= 4'b0000;
            mem_wdata   <= 32'd0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 32'd0;
        end else begin
            state_q     <= state_d;
            ld_funct3_q <= ld_funct3_d;
            ld_off_q    <= ld_off_d;
            mem_addr    <= mem_addr_d;
            mem_strb    <= mem_strb_d;
            mem_wmask   <= mem_wmask_d;
            mem_wdata   <= mem_wdata_d;
            resp_valid  <= resp_valid_d;
            resp_err    <= resp_err_d;
            resp_rdata  <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb/tb_lsu_bus_master.sv - self-checking bench for lsu_bus_master

module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_strb;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'd0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_bus_master #(.MEM_BYTES(2048), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_strb(mem_strb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    // Memory responder (driven by the DUT) and the independent reference image.
    logic [7:0] mem     [2048];
    logic [7:0] ref_mem [2048];
    bit         filled = 1'b0;

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 2048; i++) mem[i] = ref_mem[i];
            filled = 1'b1;
        end
        for (int k = 0; k < 4; k++)
            if (mem_wmask[k]) mem[{mem_addr[10:2], 2'b00} + 11'(k)] = mem_wdata[8*k +: 8];
        if (mem_strb)
            mem_rdata <= {mem[{mem_addr[10:2], 2'd0}], mem[{mem_addr[10:2], 2'd1}],
                          mem[{mem_addr[10:2], 2'd2}], mem[{mem_addr[10:2], 2'd3}]};
        else
            mem_rdata <= 32'hDEADBEEF;
    end

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit m_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        bit legal;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        sz = m_size(f3);
        if (!legal) return 1'b1;
        if ((addr % sz) != 0) return 1'b1;
        if (longint'({32'd0, addr}) + sz - 1 >= 2048) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr);
        int a, v;
        a = int'(addr);
        case (f3)
            3'd0: begin v = int'(ref_mem[a]); if (v > 127) v = v - 256; return 32'(v); end
            3'd4: return 32'(int'(ref_mem[a]));
            3'd1: begin
                v = int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]);
                if (v > 32767) v = v - 65536;
                return 32'(v);
            end
            3'd5: return 32'(int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]));
            default: return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        endcase
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [3:0] mask, output logic [31:0] data);
        int sz, off;
        sz = m_size(f3);
        off = int'(addr % 4);
        mask = 4'd0;
        data = 32'd0;
        for (int i = 0; i < sz; i++) begin
            mask[off+i] = 1'b1;
            data[8*(off+i) +: 8] = wd[8*i +: 8];
            ref_mem[int'(addr) + i] = wd[8*i +: 8];
        end
    endtask

    // ---------------- driver / observer ----------------
    bit          obs_timeout, obs_ready1, obs_err;
    int          obs_resp_cnt, obs_resp_cyc, obs_strb_cnt, obs_strb_cyc, obs_wm_cnt, obs_wm_cyc;
    logic [3:0]  obs_wmask;
    logic [31:0] obs_wdata, obs_rdata, obs_hold, obs_addr;

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        obs_timeout = !req_ready;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        obs_resp_cnt = 0; obs_resp_cyc = 0; obs_strb_cnt = 0; obs_strb_cyc = 0;
        obs_wm_cnt = 0; obs_wm_cyc = 0; obs_wmask = 4'd0; obs_wdata = 32'd0;
        obs_rdata = 32'hBADBAD00; obs_err = 1'b0; obs_hold = 32'hBADBAD00;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                obs_ready1 = req_ready;
                obs_addr = mem_addr;
                // Scramble the request fields: the DUT must have latched them.
                req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
            if (mem_strb) begin obs_strb_cnt++; obs_strb_cyc = c; end
            if (mem_wmask != 4'd0) begin
                obs_wm_cnt++; obs_wm_cyc = c; obs_wmask = mem_wmask; obs_wdata = mem_wdata;
            end
            if (resp_valid) begin
                obs_resp_cnt++; obs_resp_cyc = c; obs_rdata = resp_rdata; obs_err = resp_err;
            end
            if (c == 5) obs_hold = resp_rdata;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({resp_valid, resp_err, mem_strb, mem_wmask} !== 7'd0) begin
            fails++; $display("FAIL reset_ctrl: got %b exp 0", {resp_valid, resp_err, mem_strb, mem_wmask});
        end
        tests++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            fails++; $display("FAIL reset_data: got %h exp 0", {resp_rdata, mem_addr, mem_wdata});
        end
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
        rstn = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdata;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic        err;
    } row_t;

    task automatic test_directed();
        row_t rows[19];
        logic [3:0]  dm;
        logic [31:0] dd;
        int exp_cyc;
        rows[0]  = '{1'b1, 3'd2, 32'h10,  32'h80FF7F01, 32'h0,        4'hF, 32'h80FF7F01, 1'b0};
        rows[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h80FF7F01, 4'h0, 32'h0,        1'b0};
        rows[2]  = '{1'b0, 3'd0, 32'h12,  32'h0,        32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        rows[3]  = '{1'b0, 3'd4, 32'h12,  32'h0,        32'h000000FF, 4'h0, 32'h0,        1'b0};
        rows[4]  = '{1'b0, 3'd0, 32'h11,  32'h0,        32'h0000007F, 4'h0, 32'h0,        1'b0};
        rows[5]  = '{1'b0, 3'd1, 32'h12,  32'h0,        32'hFFFF80FF, 4'h0, 32'h0,        1'b0};
        rows[6]  = '{1'b0, 3'd5, 32'h12,  32'h0,        32'h000080FF, 4'h0, 32'h0,        1'b0};
        rows[7]  = '{1'b1, 3'd0, 32'h11,  32'h123456AA, 32'h0,        4'h2, 32'h0000AA00, 1'b0};
        rows[8]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h80FFAA01, 4'h0, 32'h0,        1'b0};
        rows[9]  = '{1'b1, 3'd1, 32'h12,  32'h0000BEEF, 32'h0,        4'hC, 32'hBEEF0000, 1'b0};
        rows[10] = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hBEEFAA01, 4'h0, 32'h0,        1'b0};
        rows[11] = '{1'b0, 3'd2, 32'h12,  32'h0,        32'h0,        4'h0, 32'h0,        1'b1};
        rows[12] = '{1'b0, 3'd2, 32'h800, 32'h0,        32'h0,        4'h0, 32'h0,        1'b1};
        rows[13] = '{1'b0, 3'd3, 32'h10,  32'h0,        32'h0,        4'h0, 32'h0,        1'b1};
        rows[14] = '{1'b1, 3'd4, 32'h10,  32'h0,        32'h0,        4'h0, 32'h0,        1'b1};
        rows[15] = '{1'b1, 3'd2, 32'h7FC, 32'h01020304, 32'h0,        4'hF, 32'h01020304, 1'b0};
        rows[16] = '{1'b0, 3'd2, 32'h7FC, 32'h0,        32'h01020304, 4'h0, 32'h0,        1'b0};
        rows[17] = '{1'b0, 3'd4, 32'h7FF, 32'h0,        32'h00000001, 4'h0, 32'h0,        1'b0};
        rows[18] = '{1'b0, 3'd0, 32'h800, 32'h0,        32'h0,        4'h0, 32'h0,        1'b1};
        for (int r = 0; r < 19; r++) begin
            issue(rows[r].we, rows[r].f3, rows[r].addr, rows[r].wd);
            if (!rows[r].err && rows[r].we) m_store(rows[r].f3, rows[r].addr, rows[r].wd, dm, dd);
            exp_cyc = rows[r].err ? 1 : (rows[r].we ? 2 : 3);
            tests++;
            if (obs_timeout || obs_ready1 !== 1'b0) begin
                fails++; $display("FAIL dir%0d_ready: timeout %0d ready1 %b exp 0/0", r, obs_timeout, obs_ready1);
            end
            tests++;
            if (obs_resp_cnt != 1 || obs_resp_cyc != exp_cyc) begin
                fails++; $display("FAIL dir%0d_resp_timing: got %0d pulses at T+%0d exp 1 at T+%0d", r, obs_resp_cnt, obs_resp_cyc, exp_cyc);
            end
            tests++;
            if (obs_err !== rows[r].err) begin
                fails++; $display("FAIL dir%0d_err: got %b exp %b", r, obs_err, rows[r].err);
            end
            tests++;
            if (obs_rdata !== rows[r].rdata || obs_hold !== rows[r].rdata) begin
                fails++; $display("FAIL dir%0d_rdata: got %h hold %h exp %h", r, obs_rdata, obs_hold, rows[r].rdata);
            end
            tests++;
            if (obs_wmask !== rows[r].mask || obs_wdata !== rows[r].wdata ||
                obs_wm_cnt != ((rows[r].mask != 0) ? 1 : 0) || (obs_wm_cnt == 1 && obs_wm_cyc != 1)) begin
                fails++; $display("FAIL dir%0d_write: mask %h data %h cnt %0d exp mask %h data %h", r, obs_wmask, obs_wdata, obs_wm_cnt, rows[r].mask, rows[r].wdata);
            end
            tests++;
            if (obs_strb_cnt != ((!rows[r].err && !rows[r].we) ? 1 : 0) || (obs_strb_cnt == 1 && obs_strb_cyc != 1)) begin
                fails++; $display("FAIL dir%0d_strb: got %0d pulses at T+%0d", r, obs_strb_cnt, obs_strb_cyc);
            end
            if (!rows[r].err) begin
                tests++;
                if (obs_addr !== {rows[r].addr[31:2], 2'b00}) begin
                    fails++; $display("FAIL dir%0d_addr: got %h exp %h", r, obs_addr, {rows[r].addr[31:2], 2'b00});
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        logic [31:0] exp;
        // Load interrupted in the wait cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'd0;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        tests++;
        if ({mem_strb, resp_valid, resp_rdata} !== 34'd0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL abort_ld_clear: strb %b rv %b rdata %h ready %b", mem_strb, resp_valid, resp_rdata, req_ready);
        end
        @(negedge clk); rstn = 1'b1;
        seen = 0;
        repeat (4) begin @(negedge clk); if (resp_valid) seen++; end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL abort_ld_resp: got %0d pulses exp 0", seen); end
        // Store interrupted while its write enables are up.
        exp = m_load(3'd2, 32'h40);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = ~exp;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        tests++;
        if (mem_wmask !== 4'hF) begin fails++; $display("FAIL abort_st_pre: wmask %h exp f", mem_wmask); end
        rstn = 1'b0;
        #1;
        tests++;
        if ({mem_wmask, mem_wdata, mem_strb} !== 37'd0) begin
            fails++; $display("FAIL abort_st_clear: wmask %h wdata %h strb %b exp 0", mem_wmask, mem_wdata, mem_strb);
        end
        @(negedge clk); rstn = 1'b1;
        seen = 0;
        repeat (4) begin @(negedge clk); if (resp_valid) seen++; end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL abort_st_resp: got %0d pulses exp 0", seen); end
        issue(1'b0, 3'd2, 32'h40, 32'd0);
        tests++;
        if (obs_rdata !== exp || obs_err !== 1'b0) begin
            fails++; $display("FAIL abort_readback: got %h err %b exp %h", obs_rdata, obs_err, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3s [3];
        logic [31:0] adrs [3];
        logic [31:0] exps [3];
        logic [31:0] got [$];
        int acc [3];
        int idx, strb_n, overlap;
        bit prev_strb;
        f3s[0] = 3'd2; f3s[1] = 3'd1; f3s[2] = 3'd4;
        for (int i = 0; i < 3; i++) begin
            adrs[i] = 32'(($urandom % 500) * 4) + ((f3s[i] == 3'd4) ? 32'd3 : 32'd0);
            exps[i] = m_load(f3s[i], adrs[i]);
            acc[i] = -100;
        end
        idx = 0; strb_n = 0; overlap = 0; prev_strb = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 24; n++) begin
            if (n > 0) @(negedge clk);
            if (resp_valid) got.push_back(resp_rdata);
            if (mem_strb) strb_n++;
            if (mem_strb && prev_strb) overlap++;
            prev_strb = mem_strb;
            if (idx < 3) begin
                req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3s[idx]; req_addr = adrs[idx];
                if (req_ready) begin acc[idx] = n; idx++; end
            end else begin
                req_valid = 1'b0;
            end
        end
        tests++;
        if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
            fails++; $display("FAIL b2b_spacing: accepts at %0d %0d %0d exp 4 apart", acc[0], acc[1], acc[2]);
        end
        tests++;
        if (strb_n != 3 || overlap != 0) begin
            fails++; $display("FAIL b2b_strb: got %0d strobes %0d overlaps exp 3/0", strb_n, overlap);
        end
        tests++;
        if (got.size() != 3) begin
            fails++; $display("FAIL b2b_count: got %0d responses exp 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (got[i] !== exps[i]) begin
                    fails++; $display("FAIL b2b_data%0d: got %h exp %h", i, got[i], exps[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic        we, e;
        logic [2:0]  f3;
        logic [31:0] addr, wd, er;
        logic [3:0]  em;
        logic [31:0] ed;
        int sz, ec;
        for (int t = 0; t < 60; t++) begin
            we = 1'($urandom); f3 = 3'($urandom); wd = $urandom;
            sz = m_size(f3);
            addr = 32'($urandom % 2112);
            if (($urandom % 4) != 0) addr = addr & ~32'(sz - 1);
            if (($urandom % 16) == 0) addr = $urandom;
            e = m_err(we, f3, addr);
            em = 4'd0; ed = 32'd0; er = 32'd0;
            if (!e && we) m_store(f3, addr, wd, em, ed);
            if (!e && !we) er = m_load(f3, addr);
            ec = e ? 1 : (we ? 2 : 3);
            issue(we, f3, addr, wd);
            tests++;
            if (obs_timeout || obs_resp_cnt != 1 || obs_resp_cyc != ec || obs_err !== e) begin
                fails++; $display("FAIL rnd%0d_resp: %0d pulses at T+%0d err %b exp T+%0d err %b (we %b f3 %0d addr %h)", t, obs_resp_cnt, obs_resp_cyc, obs_err, ec, e, we, f3, addr);
            end
            tests++;
            if (obs_rdata !== er) begin
                fails++; $display("FAIL rnd%0d_rdata: got %h exp %h (f3 %0d addr %h)", t, obs_rdata, er, f3, addr);
            end
            tests++;
            if (obs_wmask !== em || obs_wdata !== ed || obs_strb_cnt != ((!e && !we) ? 1 : 0)) begin
                fails++; $display("FAIL rnd%0d_bus: mask %h data %h strb %0d exp mask %h data %h", t, obs_wmask, obs_wdata, obs_strb_cnt, em, ed);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'($urandom);
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        test_reset();
        test_directed();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
